// File: rtl/asmd_seq_multiplier.sv
// Sequential shift-and-add multiplier built as a three-state ASMD (IDLE/RUN/DONE).
// Define ASMD_SIGNED_MULT_EN to enable two's-complement operation via signed_mode.
module asmd_seq_multiplier #(
  parameter int WORD_LENGTH = 4,
  parameter int EARLY_EXIT  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     word0,
  input  logic [WORD_LENGTH-1:0]     word1,
  input  logic                       signed_mode,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic                       ready,
  output logic                       done
);

  localparam int PW = 2 * WORD_LENGTH;
  localparam int CW = $clog2(WORD_LENGTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          mcand_q, mcand_d;
  logic [PW-1:0]          acc_q, acc_d;
  logic [PW-1:0]          product_q, product_d;
  logic [WORD_LENGTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   neg_q, neg_d;

  logic [WORD_LENGTH-1:0] op0_ld, op1_ld;
  logic                   neg_ld;

`ifdef ASMD_SIGNED_MULT_EN
  // The most negative value maps onto itself, which read unsigned is its exact magnitude.
  function automatic logic [WORD_LENGTH-1:0] magnitude(input logic [WORD_LENGTH-1:0] x);
    return x[WORD_LENGTH-1] ? -x : x;
  endfunction

  always_comb begin
    op0_ld = signed_mode ? magnitude(word0) : word0;
    op1_ld = signed_mode ? magnitude(word1) : word1;
    neg_ld = signed_mode & (word0[WORD_LENGTH-1] ^ word1[WORD_LENGTH-1]);
  end
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign op0_ld = word0;
  assign op1_ld = word1;
  assign neg_ld = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WORD_LENGTH{1'b0}}, op0_ld};
          mplier_d = op1_ld;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = neg_ld;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + CW'(1);
        if ((cnt_q == CW'(WORD_LENGTH - 1)) || ((EARLY_EXIT != 0) && (mplier_d == '0))) begin
          state_d   = DONE;
          product_d = neg_q ? -acc_d : acc_d;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_asmd_seq_multiplier.sv
// Scoreboard bench for asmd_seq_multiplier: one EARLY_EXIT=1 and one EARLY_EXIT=0 instance side by side.
`timescale 1ns/1ps
module tb_asmd_seq_multiplier;

  localparam int WL = 4;
`ifdef ASMD_SIGNED_MULT_EN
  localparam bit SIGNED_ON = 1'b1;
`else
  localparam bit SIGNED_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0]      start_s;
  logic [WL-1:0]   w0, w1;
  logic            sm;
  logic [2*WL-1:0] prod [2];
  logic [1:0]      rdy, dn;

  asmd_seq_multiplier #(.WORD_LENGTH(WL), .EARLY_EXIT(1)) u_early (
    .clk(clk), .reset(reset), .start(start_s[0]), .word0(w0), .word1(w1),
    .signed_mode(sm), .product(prod[0]), .ready(rdy[0]), .done(dn[0]));

  asmd_seq_multiplier #(.WORD_LENGTH(WL), .EARLY_EXIT(0)) u_full (
    .clk(clk), .reset(reset), .start(start_s[1]), .word0(w0), .word1(w1),
    .signed_mode(sm), .product(prod[1]), .ready(rdy[1]), .done(dn[1]));

  typedef struct {
    logic [2*WL-1:0] p;
    int              e0;
    int              e1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int              act_edge [2];
  int              pulses   [2];
  logic [2*WL-1:0] act_prod [2];
  logic [2*WL-1:0] end_prod [2];
  logic            act_rdy  [2];
  logic [1:0]      pre_rdy;

  function automatic logic [2*WL-1:0] model_prod(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                                 input logic s);
    int ia, ib;
    ia = (s && SIGNED_ON) ? int'($signed(a)) : int'(a);
    ib = (s && SIGNED_ON) ? int'($signed(b)) : int'(b);
    return (2*WL)'(ia * ib);
  endfunction

  // Edge count runs up to the edge that samples done high: RUN length plus one.
  function automatic int model_edge(input logic [WL-1:0] b, input logic s, input int early);
    logic [WL-1:0] m;
    int n;
    m = (s && SIGNED_ON && b[WL-1]) ? WL'(-b) : b;
    n = 1;
    if (early == 0) n = WL;
    else for (int i = 0; i < WL; i++) if (m[i]) n = i + 1;
    return n + 1;
  endfunction

  function automatic void push_exp(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic s);
    exp_t x;
    x.p  = model_prod(a, b, s);
    x.e0 = model_edge(b, s, 1);
    x.e1 = model_edge(b, s, 0);
    sb.push_back(x);
  endfunction

  task automatic run_op(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic s,
                        input bit hold);
    @(negedge clk);
    pre_rdy = rdy;
    w0 = a; w1 = b; sm = s; start_s = 2'b11;
    push_exp(a, b, s);
    @(posedge clk); #1;
    if (!hold) start_s = 2'b00;
    w0 = ~a; w1 = ~b; sm = ~s;
    for (int i = 0; i < 2; i++) begin
      act_edge[i] = -1; pulses[i] = 0; act_rdy[i] = 1'b0; act_prod[i] = 'x;
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (act_edge[i] > 0 && k == act_edge[i] + 1) act_rdy[i] = rdy[i];
        if (dn[i]) begin
          pulses[i]++;
          if (act_edge[i] < 0) begin
            act_edge[i] = k;
            act_prod[i] = prod[i];
            start_s[i]  = 1'b0;
          end
        end
      end
    end
    start_s = 2'b00;
    for (int i = 0; i < 2; i++) end_prod[i] = prod[i];
  endtask

  task automatic test_reset;
    reset = 1'b1; start_s = 2'b00; w0 = '0; w1 = '0; sm = 1'b0;
    @(negedge clk);
    checks++; if (prod[0] !== '0 || prod[1] !== '0) begin
      errors++; $display("FAIL reset_product got %h/%h want 00", prod[0], prod[1]); end
    checks++; if (rdy !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b want 11", rdy); end
    checks++; if (dn !== 2'b00) begin
      errors++; $display("FAIL reset_done got %b want 00", dn); end
    @(posedge clk); #2 reset = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [WL-1:0] ta [6] = '{4'd3, 4'd15, 4'd7, 4'd0, 4'd10, 4'd1};
    logic [WL-1:0] tb [6] = '{4'd2, 4'd15, 4'd0, 4'd9, 4'd13, 4'd8};
    exp_t x;
    int ee;
    for (int t = 0; t < 6; t++) begin
      run_op(ta[t], tb[t], 1'b0, 1'b0);
      x = sb.pop_front();
      for (int i = 0; i < 2; i++) begin
        ee = (i == 0) ? x.e0 : x.e1;
        checks++; if (pre_rdy[i] !== 1'b1) begin
          errors++; $display("FAIL u%0d ready_before %0d*%0d got %b want 1", i, ta[t], tb[t], pre_rdy[i]); end
        checks++; if (act_prod[i] !== x.p) begin
          errors++; $display("FAIL u%0d product %0d*%0d got %h want %h", i, ta[t], tb[t], act_prod[i], x.p); end
        checks++; if (act_edge[i] != ee) begin
          errors++; $display("FAIL u%0d done_edge %0d*%0d got %0d want %0d", i, ta[t], tb[t], act_edge[i], ee); end
        checks++; if (pulses[i] != 1) begin
          errors++; $display("FAIL u%0d done_pulses %0d*%0d got %0d want 1", i, ta[t], tb[t], pulses[i]); end
        checks++; if (act_rdy[i] !== 1'b1) begin
          errors++; $display("FAIL u%0d ready_after %0d*%0d got %b want 1", i, ta[t], tb[t], act_rdy[i]); end
        checks++; if (end_prod[i] !== x.p) begin
          errors++; $display("FAIL u%0d product_hold got %h want %h", i, end_prod[i], x.p); end
      end
    end
  endtask

  task automatic test_signed_mode;
    logic [WL-1:0] ta [4] = '{4'hD, 4'h8, 4'h5, 4'hD};
    logic [WL-1:0] tb [4] = '{4'h5, 4'h8, 4'hD, 4'h5};
    logic          ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_t x;
    int ee;
    for (int t = 0; t < 4; t++) begin
      run_op(ta[t], tb[t], ts[t], 1'b0);
      x = sb.pop_front();
      for (int i = 0; i < 2; i++) begin
        ee = (i == 0) ? x.e0 : x.e1;
        checks++; if (act_prod[i] !== x.p) begin
          errors++; $display("FAIL u%0d sproduct %h*%h sm=%b got %h want %h", i, ta[t], tb[t], ts[t], act_prod[i], x.p); end
        checks++; if (act_edge[i] != ee) begin
          errors++; $display("FAIL u%0d sdone_edge %h*%h got %0d want %0d", i, ta[t], tb[t], act_edge[i], ee); end
        checks++; if (pulses[i] != 1) begin
          errors++; $display("FAIL u%0d sdone_pulses got %0d want 1", i, pulses[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    exp_t x;
    int ee;
    int stray;
    @(negedge clk);
    w0 = 4'd15; w1 = 4'd15; sm = 1'b0; start_s = 2'b11;
    @(posedge clk); #1 start_s = 2'b00;
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    #1;
    checks++; if (prod[0] !== '0 || prod[1] !== '0) begin
      errors++; $display("FAIL midrun_product got %h/%h want 00", prod[0], prod[1]); end
    checks++; if (rdy !== 2'b11) begin
      errors++; $display("FAIL midrun_ready got %b want 11", rdy); end
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dn != 2'b00) stray++;
      if (k == 2) reset = 1'b0;
    end
    checks++; if (stray != 0) begin
      errors++; $display("FAIL midrun_no_done got %0d pulses want 0", stray); end
    run_op(4'd3, 4'd2, 1'b0, 1'b0);
    x = sb.pop_front();
    for (int i = 0; i < 2; i++) begin
      ee = (i == 0) ? x.e0 : x.e1;
      checks++; if (act_prod[i] !== x.p) begin
        errors++; $display("FAIL u%0d after_reset product got %h want %h", i, act_prod[i], x.p); end
      checks++; if (act_edge[i] != ee) begin
        errors++; $display("FAIL u%0d after_reset done_edge got %0d want %0d", i, act_edge[i], ee); end
    end
  endtask

  task automatic test_start_held;
    exp_t x;
    int ee;
    run_op(4'd3, 4'd2, 1'b0, 1'b1);
    x = sb.pop_front();
    for (int i = 0; i < 2; i++) begin
      ee = (i == 0) ? x.e0 : x.e1;
      checks++; if (act_prod[i] !== x.p) begin
        errors++; $display("FAIL u%0d held_product got %h want %h", i, act_prod[i], x.p); end
      checks++; if (act_edge[i] != ee) begin
        errors++; $display("FAIL u%0d held_done_edge got %0d want %0d", i, act_edge[i], ee); end
      checks++; if (pulses[i] != 1) begin
        errors++; $display("FAIL u%0d held_done_pulses got %0d want 1", i, pulses[i]); end
      checks++; if (end_prod[i] !== x.p) begin
        errors++; $display("FAIL u%0d held_product_hold got %h want %h", i, end_prod[i], x.p); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_mode();
    test_reset_mid_run();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/asmd_seq_multiplier.md
ASMD_SEQ_MULTIPLIER -- requirements
Module: asmd_seq_multiplier

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 4: operand width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter EARLY_EXIT, default 1: 1 ends iteration once the remaining multiplier bits are zero; 0 always runs WORD_LENGTH iterations.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request.
REQ-006 The block SHALL have port word0, input, WORD_LENGTH bits: multiplicand.
REQ-007 The block SHALL have port word1, input, WORD_LENGTH bits: multiplier.
REQ-008 The block SHALL have port signed_mode, input, 1 bit: operands and result are two's complement when 1.
REQ-009 The block SHALL have port product, output, 2*WORD_LENGTH bits: registered result.
REQ-010 The block SHALL have port ready, output, 1 bit: block is idle and accepts start.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse, product valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 ready SHALL be 1 only in IDLE; done SHALL be 1 only in DONE.
REQ-014 start SHALL be sampled only in IDLE; start=1 SHALL register word0, word1 and signed_mode, clear the accumulator and move the FSM to RUN.
REQ-015 start asserted in RUN or DONE SHALL be ignored and SHALL have no effect on state, operands or product.
REQ-016 Each RUN cycle SHALL add the shifted multiplicand to the accumulator when the current multiplier LSB is 1, then shift the multiplier right and the multiplicand left by one bit.
REQ-017 RUN SHALL exit to DONE after the cycle that processes bit WORD_LENGTH-1, or, when EARLY_EXIT=1, after the first cycle that leaves the remaining multiplier zero.
REQ-018 RUN SHALL last at least 1 cycle; word1=0 with EARLY_EXIT=1 SHALL give exactly 1 RUN cycle.
REQ-019 RUN SHALL last n cycles, where n = max(1, index of the highest set bit of the operative multiplier + 1), or n = WORD_LENGTH when EARLY_EXIT=0.
REQ-020 done SHALL assert exactly n+1 rising edges after the edge that accepted start.
REQ-021 The DONE state SHALL last one cycle and SHALL then return to IDLE unconditionally.
REQ-022 product SHALL update only on entry to DONE.
REQ-023 product SHALL hold its value until the next DONE or reset.
REQ-024 Unsigned arithmetic SHALL be exact with no overflow: a 2*WORD_LENGTH-bit result of WORD_LENGTH-bit operands.

Reset
REQ-025 reset=1 SHALL force, asynchronously and regardless of state: FSM to IDLE, product=0, done=0, ready=1, and internal operand, accumulator and count registers to 0.
REQ-026 reset asserted in RUN or DONE SHALL abort the operation with no done pulse.
REQ-027 After reset release the block SHALL accept start on the first rising edge.

Configuration
REQ-028 With macro ASMD_SIGNED_MULT_EN defined, signed_mode=1 SHALL convert operands to magnitudes at load, run the unsigned iteration on magnitudes, and negate the result at DONE when the operand signs differ.
REQ-029 With ASMD_SIGNED_MULT_EN defined, the most negative operand (e.g. -8 for WORD_LENGTH=4) SHALL be handled exactly; -8*-8 SHALL give 64.
REQ-030 With ASMD_SIGNED_MULT_EN defined, n SHALL be computed from the multiplier magnitude.
REQ-031 Without ASMD_SIGNED_MULT_EN, the signed_mode port SHALL remain present but be ignored, and all operations SHALL be unsigned.

Verification
REQ-032 Bench SHALL cover: WORD_LENGTH=4, EARLY_EXIT=1, 3*2 -> product=8'd6, done 3 edges after start accepted, ready=1 the following cycle.
REQ-033 Bench SHALL cover: 15*15, EARLY_EXIT=0 and =1 -> product=8'd225, done 5 edges after start in both.
REQ-034 Bench SHALL cover: 7*0, EARLY_EXIT=1 -> product=0, done 2 edges after start.
REQ-035 Bench SHALL cover: with ASMD_SIGNED_MULT_EN and signed_mode=1: -3*5 -> 8'hF1; -8*-8 -> 8'h40; without the macro, 4'hD*4'h5 -> 8'd65.
REQ-036 Bench SHALL cover: reset pulsed mid-RUN -> product=0 and ready=1 immediately, no done pulse, and the next 3*2 gives 6.
REQ-037 Bench SHALL cover: start held high through RUN with word0/word1 changed -> result uses the originally latched operands, and exactly one done pulse per accepted start.
